// File: rtl/fft_agu_param_if.sv
// Bundle between the FFT controller/host and the address generation unit.
// The optional stall line exists only when FFT_AGU_STALL_EN is defined.
interface fft_agu_param_if #(
  parameter int LOG2N = 5
);
  logic             start_fft;
`ifdef FFT_AGU_STALL_EN
  logic             stall;
`endif
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             rd_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             wr_en;
  logic             bank_sel;
  logic             busy;
  logic             fft_done;

`ifdef FFT_AGU_STALL_EN
  modport master (
    output start_fft, stall,
    input  rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_addr_a, wr_addr_b,
           wr_en, bank_sel, busy, fft_done
  );
  modport slave (
    input  start_fft, stall,
    output rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_addr_a, wr_addr_b,
           wr_en, bank_sel, busy, fft_done
  );
`else
  modport master (
    output start_fft,
    input  rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_addr_a, wr_addr_b,
           wr_en, bank_sel, busy, fft_done
  );
  modport slave (
    input  start_fft,
    output rd_addr_a, rd_addr_b, tw_addr, rd_en, wr_addr_a, wr_addr_b,
           wr_en, bank_sel, busy, fft_done
  );
`endif
endinterface

// File: rtl/fft_agu_param.sv
// Address generation unit for an in-place constant-geometry radix-2 FFT
// over two ping-pong banks. Issues operand/twiddle read addresses for
// LOG2N stages of N/2 butterflies, replays them as write addresses after
// PIPE_LAT cycles, flips the read bank between stages and pulses fft_done.
// Optional feature macro: FFT_AGU_STALL_EN (adds a sequencer freeze input).
module fft_agu_param #(
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic           clk,
  input  logic           sclr,
  fft_agu_param_if.slave bus
);

  localparam int JW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [JW-1:0]    r_j;
  logic [SW-1:0]    r_s;
  logic [DW-1:0]    r_dcnt;
  logic             r_start_q;
  logic             r_bank;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [LOG2N-1:0] r_rd_a;
  logic [LOG2N-1:0] r_rd_b;
  logic [JW-1:0]    r_tw;

  logic             r_vld_p  [PIPE_LAT];
  logic [LOG2N-1:0] r_wa_p   [PIPE_LAT];
  logic [LOG2N-1:0] r_wb_p   [PIPE_LAT];

  logic             w_stall;
  logic             w_hold;
  logic             w_start_edge;
  logic [JW-1:0]    w_j_inc;
  logic [SW-1:0]    w_s_inc;

  // Modulo-LOG2N left rotate; fields never carry into each other.
  function automatic logic [LOG2N-1:0] f_rotl(input logic [LOG2N-1:0] x,
                                              input logic [SW-1:0]    s);
    logic [2*LOG2N-1:0] w_dbl;
    w_dbl = {x, x} << s;
    return w_dbl[2*LOG2N-1:LOG2N];
  endfunction

  // Twiddle index keeps only the top s bits of j (stage 0 always uses W^0).
  function automatic logic [JW-1:0] f_twiddle(input logic [JW-1:0] j,
                                              input logic [SW-1:0] s);
    logic [JW-1:0] w_mask;
    w_mask = ~({JW{1'b1}} >> s);
    return j & w_mask;
  endfunction

`ifdef FFT_AGU_STALL_EN
  assign w_stall = bus.stall;
`else
  assign w_stall = 1'b0;
`endif

  // Stall only freezes an active transform; IDLE and DONE run regardless.
  assign w_hold       = w_stall & r_busy;
  assign w_start_edge = bus.start_fft & ~r_start_q;
  assign w_j_inc      = r_j + JW'(1);
  assign w_s_inc      = r_s + SW'(1);

  // Sequencer: walks butterflies within a stage, drains, then advances stage.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state   <= S_IDLE;
      r_j       <= '0;
      r_s       <= '0;
      r_dcnt    <= '0;
      r_start_q <= 1'b0;
      r_bank    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_a    <= '0;
      r_rd_b    <= '0;
      r_tw      <= '0;
    end else begin
      r_start_q <= bus.start_fft;
      r_done    <= 1'b0;
      if (!w_hold) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_start_edge) begin
              r_state <= S_READ;
              r_j     <= '0;
              r_s     <= '0;
              r_bank  <= 1'b0;
              r_busy  <= 1'b1;
              r_rd_en <= 1'b1;
              r_rd_a  <= '0;
              r_rd_b  <= LOG2N'(1);
              r_tw    <= '0;
            end
          end
          S_READ: begin
            if (r_j == J_LAST) begin
              r_state <= S_DRAIN;
              r_rd_en <= 1'b0;
              r_dcnt  <= '0;
            end else begin
              r_j     <= w_j_inc;
              r_rd_en <= 1'b1;
              r_rd_a  <= f_rotl({w_j_inc, 1'b0}, r_s);
              r_rd_b  <= f_rotl({w_j_inc, 1'b1}, r_s);
              r_tw    <= f_twiddle(w_j_inc, r_s);
            end
          end
          S_DRAIN: begin
            if (r_dcnt == D_LAST) begin
              // Last write of this stage lands in this cycle; swap banks now.
              r_bank <= ~r_bank;
              r_dcnt <= '0;
              if (r_s != S_LAST) begin
                r_state <= S_READ;
                r_s     <= w_s_inc;
                r_j     <= '0;
                r_rd_en <= 1'b1;
                r_rd_a  <= '0;
                r_rd_b  <= f_rotl(LOG2N'(1), w_s_inc);
                r_tw    <= '0;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Write-side delay line: stage _p0 takes the read side, last stage feeds writes.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_vld_p[i] <= 1'b0;
        r_wa_p[i]  <= '0;
        r_wb_p[i]  <= '0;
      end
    end else if (!w_hold) begin
      r_vld_p[0] <= r_rd_en;
      r_wa_p[0]  <= r_rd_a;
      r_wb_p[0]  <= r_rd_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_wa_p[i]  <= r_wa_p[i-1];
        r_wb_p[i]  <= r_wb_p[i-1];
      end
    end
  end

  assign bus.rd_addr_a = r_rd_a;
  assign bus.rd_addr_b = r_rd_b;
  assign bus.tw_addr   = r_tw;
  assign bus.rd_en     = r_rd_en & ~w_hold;
  assign bus.wr_addr_a = r_wa_p[PIPE_LAT-1];
  assign bus.wr_addr_b = r_wb_p[PIPE_LAT-1];
  assign bus.wr_en     = r_vld_p[PIPE_LAT-1] & ~w_hold;
  assign bus.bank_sel  = r_bank;
  assign bus.busy      = r_busy;
  assign bus.fft_done  = r_done;

endmodule
